// File: rtl/ai_pkg.sv
// Shared types and constants for the shot-engine sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ai_pkg;

  localparam int         CELLS       = 100;
  localparam logic [6:0] NO_MOVE_IDX = 7'd127;

  // Engine register map (4-bit address space).
  typedef enum logic [3:0] {
    ADDR_START  = 4'd0,
    ADDR_FIRED0 = 4'd1,
    ADDR_FIRED1 = 4'd2,
    ADDR_FIRED2 = 4'd3,
    ADDR_FIRED3 = 4'd4,
    ADDR_HITS0  = 4'd5,
    ADDR_HITS1  = 4'd6,
    ADDR_HITS2  = 4'd7,
    ADDR_HITS3  = 4'd8,
    ADDR_SHIPS  = 4'd9
  } ai_addr_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_READ,
    S_CAPTURE,
    S_CHECK,
    S_SCAN,
    S_DONE
  } seq_state_e;

  // Alive-ship mask bit positions.
  localparam int SHIP_LEN2  = 0;
  localparam int SHIP_LEN3A = 1;
  localparam int SHIP_LEN3B = 2;
  localparam int SHIP_LEN4  = 3;
  localparam int SHIP_LEN5  = 4;

  localparam logic [4:0] SHIPS_ALL = 5'b11111;

endpackage

// File: rtl/ai_word_mux.sv
// Config word formatter: maps a register index plus board snapshot to the 32-bit write data.
// Latency: combinational.
// Backpressure: none; the caller holds i_word stable while the engine stalls.
// Ports: i_word (register index), i_fired/i_hits (board bitmaps), i_ships (alive mask), o_wdata.
module ai_word_mux
#(
  parameter int CELLS = 100
)(
  input  logic [3:0]       i_word,
  input  logic [CELLS-1:0] i_fired,
  input  logic [CELLS-1:0] i_hits,
  input  logic [4:0]       i_ships,
  output logic [31:0]      o_wdata
);
  import ai_pkg::*;

  // Zero-extend the bitmaps to four full words so the top word pads cleanly.
  logic [127:0] w_fired_pad;
  logic [127:0] w_hits_pad;

  assign w_fired_pad = {{(128-CELLS){1'b0}}, i_fired};
  assign w_hits_pad  = {{(128-CELLS){1'b0}}, i_hits};

  always_comb begin
    o_wdata = '0;
    case (i_word)
      ADDR_FIRED0: o_wdata = w_fired_pad[31:0];
      ADDR_FIRED1: o_wdata = w_fired_pad[63:32];
      ADDR_FIRED2: o_wdata = w_fired_pad[95:64];
      ADDR_FIRED3: o_wdata = w_fired_pad[127:96];
      ADDR_HITS0:  o_wdata = w_hits_pad[31:0];
      ADDR_HITS1:  o_wdata = w_hits_pad[63:32];
      ADDR_HITS2:  o_wdata = w_hits_pad[95:64];
      ADDR_HITS3:  o_wdata = w_hits_pad[127:96];
      ADDR_SHIPS:  o_wdata = {27'd0, i_ships};
      default:     o_wdata = '0;
    endcase
  end

endmodule

// File: rtl/ai_sequencer.sv
// Move sequencer: snapshots the board, programs the shot engine, validates its pick, falls back to a linear scan.
// Latency: ~10 write cycles + engine run + 3 read/check cycles; scan fallback adds up to CELLS cycles; no-move resolves in 1 cycle.
// Backpressure: ai_wait_request stalls each config/start write indefinitely; the engine busy period is bounded by TIMEOUT_CYCLES.
// Ports: req/busy/done handshake to game control; fired_in/hits_in/ships_in board state; shot_index/fallback/no_move/
//        timeout_err results; ai_* is the engine register bus (addr, write/read strobes, wdata, wait_request, rdata).
module ai_sequencer
#(
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int CELLS          = ai_pkg::CELLS
)(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req,
  input  logic [CELLS-1:0] fired_in,
  input  logic [CELLS-1:0] hits_in,
  input  logic [4:0]       ships_in,
  output logic             busy,
  output logic             done,
  output logic [6:0]       shot_index,
  output logic             fallback,
  output logic             no_move,
  output logic             timeout_err,
  output logic [3:0]       ai_addr,
  output logic             ai_write_en,
  output logic             ai_read_en,
  output logic [31:0]      ai_wdata,
  input  logic             ai_wait_request,
  input  logic [31:0]      ai_rdata
);
  import ai_pkg::*;

  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]       LAST_CELL = 7'(CELLS - 1);

  seq_state_e       r_state;
  logic [3:0]       r_word;
  logic [TMO_W-1:0] r_tmo;
  logic [6:0]       r_pos;
  logic [6:0]       r_idx;
  logic [CELLS-1:0] r_fired;
  logic [CELLS-1:0] r_hits;
  logic [4:0]       r_ships;

  logic             r_busy;
  logic             r_done;
  logic [6:0]       r_shot;
  logic             r_fallback;
  logic             r_no_move;
  logic             r_tmo_err;
  logic [3:0]       r_addr;
  logic             r_we;
  logic             r_re;
  logic [31:0]      r_wdata;

  logic [3:0]       w_next_word;
  logic [CELLS-1:0] w_src_fired;
  logic [CELLS-1:0] w_src_hits;
  logic [4:0]       w_src_ships;
  logic [31:0]      w_word_dat;
  logic [TMO_W-1:0] w_tmo_inc;
  logic             w_rdata_unused;

  // The first word is registered on the accept edge, before the snapshot
  // registers hold the board, so the mux reads the live inputs in IDLE.
  assign w_next_word = (r_state == S_IDLE) ? 4'd1 : r_word + 4'd1;
  assign w_src_fired = (r_state == S_IDLE) ? fired_in : r_fired;
  assign w_src_hits  = (r_state == S_IDLE) ? hits_in  : r_hits;
  assign w_src_ships = (r_state == S_IDLE) ? ships_in : r_ships;

  assign w_tmo_inc      = (r_tmo == '1) ? r_tmo : r_tmo + TMO_W'(1);
  assign w_rdata_unused = ^ai_rdata[31:7];

  ai_word_mux #(.CELLS(CELLS)) u_word_mux (
    .i_word  (w_next_word),
    .i_fired (w_src_fired),
    .i_hits  (w_src_hits),
    .i_ships (w_src_ships),
    .o_wdata (w_word_dat)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_tmo      <= '0;
      r_pos      <= '0;
      r_idx      <= '0;
      r_fired    <= '0;
      r_hits     <= '0;
      r_ships    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shot     <= '0;
      r_fallback <= 1'b0;
      r_no_move  <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_fired    <= fired_in;
            r_hits     <= hits_in;
            r_ships    <= ships_in;
            r_fallback <= 1'b0;
            r_no_move  <= 1'b0;
            r_tmo_err  <= 1'b0;
            if (ships_in == '0 || &fired_in) begin
              // Nothing to shoot at: answer immediately, engine untouched.
              r_no_move <= 1'b1;
              r_shot    <= NO_MOVE_IDX;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_word  <= w_next_word;
              r_addr  <= w_next_word;
              r_wdata <= w_word_dat;
              r_we    <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (!ai_wait_request) begin
            if (r_word == ADDR_SHIPS) begin
              r_addr  <= ADDR_START;
              r_wdata <= '0;
              r_state <= S_START;
            end else begin
              r_word  <= w_next_word;
              r_addr  <= w_next_word;
              r_wdata <= w_word_dat;
            end
          end
        end

        S_START: begin
          if (!ai_wait_request) begin
            r_we    <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_WAIT_BUSY;
          end
        end

        // The engine signals its run by raising wait_request; a missing
        // rising edge counts against the same timeout as a stuck run.
        S_WAIT_BUSY: begin
          r_tmo <= w_tmo_inc;
          if (ai_wait_request) begin
            r_state <= S_WAIT_DONE;
          end else if (r_tmo == TMO_LAST) begin
            r_tmo_err <= 1'b1;
            r_pos     <= '0;
            r_state   <= S_SCAN;
          end
        end

        S_WAIT_DONE: begin
          r_tmo <= w_tmo_inc;
          if (!ai_wait_request) begin
            r_re    <= 1'b1;
            r_addr  <= ADDR_START;
            r_state <= S_READ;
          end else if (r_tmo == TMO_LAST) begin
            r_tmo_err <= 1'b1;
            r_pos     <= '0;
            r_state   <= S_SCAN;
          end
        end

        S_READ: begin
          r_re    <= 1'b0;
          r_state <= S_CAPTURE;
        end

        // Engine read data is registered, so it is valid the cycle after the strobe.
        S_CAPTURE: begin
          r_idx   <= ai_rdata[6:0];
          r_state <= S_CHECK;
        end

        S_CHECK: begin
          if (r_idx > LAST_CELL) begin
            r_pos   <= '0;
            r_state <= S_SCAN;
          end else if (r_fired[r_idx]) begin
            r_pos   <= '0;
            r_state <= S_SCAN;
          end else begin
            r_shot  <= r_idx;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_SCAN: begin
          if (!r_fired[r_pos]) begin
            r_shot     <= r_pos;
            r_fallback <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_pos == LAST_CELL) begin
            r_shot    <= NO_MOVE_IDX;
            r_no_move <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_pos <= r_pos + 7'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign shot_index  = r_shot;
  assign fallback    = r_fallback;
  assign no_move     = r_no_move;
  assign timeout_err = r_tmo_err;
  assign ai_addr     = r_addr;
  assign ai_write_en = r_we;
  assign ai_read_en  = r_re;
  assign ai_wdata    = r_wdata;

endmodule

// File: tb/tb_ai_sequencer.sv
module tb_ai_sequencer;
  import ai_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n  = 1'b0;
  logic        req      = 1'b0;
  logic [99:0] fired_in = '0;
  logic [99:0] hits_in  = '0;
  logic [4:0]  ships_in = '0;
  logic        busy, done, fallback, no_move, timeout_err, ai_write_en, ai_read_en;
  logic [6:0]  shot_index;
  logic [3:0]  ai_addr;
  logic [31:0] ai_wdata;
  logic        ai_wait_request = 1'b0;
  logic [31:0] ai_rdata        = '0;

  ai_sequencer #(.TIMEOUT_CYCLES(16), .CELLS(100)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req             (req),
    .fired_in        (fired_in),
    .hits_in         (hits_in),
    .ships_in        (ships_in),
    .busy            (busy),
    .done            (done),
    .shot_index      (shot_index),
    .fallback        (fallback),
    .no_move         (no_move),
    .timeout_err     (timeout_err),
    .ai_addr         (ai_addr),
    .ai_write_en     (ai_write_en),
    .ai_read_en      (ai_read_en),
    .ai_wdata        (ai_wdata),
    .ai_wait_request (ai_wait_request),
    .ai_rdata        (ai_rdata)
  );

  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [6:0] shot; logic fb; logic nm; logic to; } res_t;
  wr_t  wq[$];
  res_t rq[$];
  wr_t  we;
  res_t re;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // engine stub knobs
  int         busy_len   = 5;
  bit         hang       = 1'b0;
  int         stall_req  = 0;
  logic [6:0] eng_result = '0;
  // engine stub observations
  int stall_used = 0, eng_cnt = 0, n_wr = 0, n_rd = 0, starts = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0;

  // Expected config word, built bit by bit from the board vectors.
  function automatic logic [31:0] wword(int k, logic [99:0] f, logic [99:0] h, logic [4:0] s);
    logic [31:0] w;
    w = '0;
    if (k == 9) w = {27'd0, s};
    else if (k >= 1 && k <= 8) begin
      for (int b = 0; b < 32; b++) begin
        int i;
        i = 32 * ((k - 1) % 4) + b;
        if (i < 100) w[b] = (k <= 4) ? f[i] : h[i];
      end
    end
    return w;
  endfunction

  // Engine stub + write/result scoreboard, evaluated on the falling edge.
  task automatic engine_stub();
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        ai_wait_request = 1'b0;
        eng_cnt = 0;
      end else begin
        if (ai_write_en && ai_read_en) begin
          total++; bad++;
          $display("FAIL strobe_excl write_en=%0b read_en=%0b required not both", ai_write_en, ai_read_en);
        end
        if (ai_write_en) n_wr++;
        if (ai_read_en)  n_rd++;
        if (ai_write_en) begin
          eng_cnt = 0;
          if (ai_addr == 4'd5 && stall_used < stall_req) begin
            ai_wait_request = 1'b1;
            stall_used++;
            total++;
            if (wq.size() == 0 || wq[0].a !== 4'd5 || ai_wdata !== wq[0].d) begin
              bad++;
              $display("FAIL stall_hold addr=%0d data=%h required addr=5 with word5 data", ai_addr, ai_wdata);
            end
          end else begin
            ai_wait_request = 1'b0;
            total++;
            if (wq.size() == 0) begin
              bad++;
              $display("FAIL write_extra addr=%0d data=%h required no write", ai_addr, ai_wdata);
            end else begin
              we = wq.pop_front();
              if (ai_addr !== we.a || ai_wdata !== we.d) begin
                bad++;
                $display("FAIL write_seq addr=%0d data=%h required addr=%0d data=%h", ai_addr, ai_wdata, we.a, we.d);
              end
            end
            if (ai_addr == 4'd0) begin
              eng_cnt = busy_len;
              starts++;
              start_cyc = cyc + 1;
            end
          end
        end else if (eng_cnt > 0) begin
          ai_wait_request = 1'b1;
          if (!hang) eng_cnt--;
        end else begin
          ai_wait_request = 1'b0;
        end
        if (ai_read_en) ai_rdata = {25'd0, eng_result};
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          total++;
          if (rq.size() == 0) begin
            bad++;
            $display("FAIL done_extra shot=%0d required no done", shot_index);
          end else begin
            re = rq.pop_front();
            if (shot_index !== re.shot || fallback !== re.fb || no_move !== re.nm ||
                timeout_err !== re.to || busy !== 1'b0) begin
              bad++;
              $display("FAIL result shot=%0d fb=%0b nm=%0b to=%0b busy=%0b required shot=%0d fb=%0b nm=%0b to=%0b busy=0",
                       shot_index, fallback, no_move, timeout_err, busy, re.shot, re.fb, re.nm, re.to);
            end
          end
        end
      end
    end
  endtask

  // One request; expectations are queued before the request is driven.
  task automatic run_move(input logic [99:0] f, input logic [99:0] h, input logic [4:0] s,
                          input logic [6:0] eres, input logic [6:0] shot, input logic fb,
                          input logic nm, input logic to, output int lat);
    int d0;
    int acc;
    d0 = done_cnt;
    fired_in = f; hits_in = h; ships_in = s; eng_result = eres;
    if (!(s == 5'd0 || &f)) begin
      for (int k = 1; k <= 9; k++) wq.push_back('{4'(k), wword(k, f, h, s)});
      wq.push_back('{4'd0, 32'd0});
    end
    rq.push_back('{shot, fb, nm, to});
    @(negedge clock);
    req = 1'b1;
    acc = cyc + 1;
    @(posedge clock);
    #1;
    req = 1'b0;
    // snapshot must be immune to later input changes
    fired_in = ~f; hits_in = ~h; ships_in = ~s;
    for (int n = 0; n < 600 && done_cnt == d0; n++) @(posedge clock);
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL done_timeout done_cnt=%0d required %0d", done_cnt, d0 + 1);
    end
    total++;
    if (wq.size() != 0) begin
      bad++;
      $display("FAIL writes_missing left=%0d required 0", wq.size());
      wq.delete();
    end
    lat = done_cyc - acc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_handshake busy=%0b done=%0b required 0 0", busy, done); end
    total++; if ({fallback, no_move, timeout_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b required 000", {fallback, no_move, timeout_err}); end
    total++; if ({ai_write_en, ai_read_en} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b required 00", {ai_write_en, ai_read_en}); end
    total++; if (ai_addr !== 4'd0 || ai_wdata !== 32'd0 || shot_index !== 7'd0) begin
      bad++; $display("FAIL rst_data addr=%0d wdata=%h shot=%0d required 0 0 0", ai_addr, ai_wdata, shot_index);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_engine_ok();
    logic [99:0] f, h;
    int lat, w0, r0;
    f = '0; h = '0;
    f[10] = 1'b1; f[33] = 1'b1; f[64] = 1'b1; f[99] = 1'b1;
    h[10] = 1'b1; h[64] = 1'b1;
    w0 = n_wr; r0 = n_rd;
    run_move(f, h, (5'd1 << SHIP_LEN2) | (5'd1 << SHIP_LEN4), 7'd44, 7'd44, 1'b0, 1'b0, 1'b0, lat);
    total++; if (n_wr - w0 != 10 || n_rd - r0 != 1) begin
      bad++; $display("FAIL strobe_count wr=%0d rd=%0d required 10 1", n_wr - w0, n_rd - r0);
    end
    run_move('0, '0, SHIPS_ALL, 7'd44, 7'd44, 1'b0, 1'b0, 1'b0, lat);
    f = '0; f[0] = 1'b1;
    run_move(f, '0, (5'd1 << SHIP_LEN3A) | (5'd1 << SHIP_LEN3B) | (5'd1 << SHIP_LEN5),
             7'd99, 7'd99, 1'b0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_fallback();
    logic [99:0] f;
    int lat;
    f = '0; f[0] = 1'b1; f[1] = 1'b1;
    run_move(f, '0, SHIPS_ALL, 7'd0, 7'd2, 1'b1, 1'b0, 1'b0, lat);
    f = '0; f[4:0] = 5'b11111;
    run_move(f, '0, SHIPS_ALL, 7'd100, 7'd5, 1'b1, 1'b0, 1'b0, lat);
    run_move('0, '0, SHIPS_ALL, 7'd120, 7'd0, 1'b1, 1'b0, 1'b0, lat);
    f = '1; f[99] = 1'b0;
    run_move(f, '0, SHIPS_ALL, 7'd3, 7'd99, 1'b1, 1'b0, 1'b0, lat);
  endtask

  task automatic test_timeout();
    int lat;
    hang = 1'b1;
    run_move('0, '0, SHIPS_ALL, 7'd50, 7'd0, 1'b1, 1'b0, 1'b1, lat);
    total++; if (done_cyc - start_cyc != 17) begin
      bad++; $display("FAIL timeout_latency cycles=%0d required 17", done_cyc - start_cyc);
    end
    total++; if (timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky timeout_err=%0b required 1", timeout_err);
    end
    hang = 1'b0;
  endtask

  task automatic test_no_move();
    logic [99:0] f;
    int lat, w0, r0;
    w0 = n_wr; r0 = n_rd;
    f = '0; f[7] = 1'b1;
    run_move(f, '0, 5'd0, 7'd0, NO_MOVE_IDX, 1'b0, 1'b1, 1'b0, lat);
    total++; if (lat != 0) begin bad++; $display("FAIL nomove_latency cycles=%0d required 0", lat); end
    run_move('1, '0, SHIPS_ALL, 7'd0, NO_MOVE_IDX, 1'b0, 1'b1, 1'b0, lat);
    total++; if (n_wr != w0 || n_rd != r0) begin
      bad++; $display("FAIL nomove_strobes wr=%0d rd=%0d required 0 0", n_wr - w0, n_rd - r0);
    end
  endtask

  task automatic test_stall();
    logic [99:0] f, h;
    int lat, s0;
    f = '0; h = '0;
    f[2] = 1'b1; f[40] = 1'b1; h[2] = 1'b1; h[37] = 1'b1; h[98] = 1'b1;
    s0 = stall_used;
    stall_req = stall_used + 3;
    run_move(f, h, SHIPS_ALL, 7'd60, 7'd60, 1'b0, 1'b0, 1'b0, lat);
    total++; if (stall_used - s0 != 3) begin
      bad++; $display("FAIL stall_cycles got=%0d required 3", stall_used - s0);
    end
  endtask

  task automatic test_reset_midrun();
    int st0, lat;
    st0 = starts;
    busy_len = 60;
    fired_in = '0; hits_in = '0; ships_in = SHIPS_ALL;
    for (int k = 1; k <= 9; k++) wq.push_back('{4'(k), wword(k, '0, '0, SHIPS_ALL)});
    wq.push_back('{4'd0, 32'd0});
    @(negedge clock);
    req = 1'b1;
    @(posedge clock);
    #1;
    req = 1'b0;
    for (int n = 0; n < 200 && starts == st0; n++) @(posedge clock);
    total++; if (starts == st0) begin bad++; $display("FAIL midrun_start starts=%0d required %0d", starts, st0 + 1); end
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    total++; if (busy !== 1'b0 || ai_write_en !== 1'b0 || ai_read_en !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midrun_abort busy=%0b we=%0b re=%0b done=%0b required 0 0 0 0", busy, ai_write_en, ai_read_en, done);
    end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    wq.delete();
    busy_len = 5;
    run_move('0, '0, SHIPS_ALL, 7'd12, 7'd12, 1'b0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_back_to_back();
    logic [99:0] f;
    int d0;
    f = '0; f[44] = 1'b1;
    d0 = done_cnt;
    fired_in = f; hits_in = '0; ships_in = SHIPS_ALL; eng_result = 7'd44;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 9; k++) wq.push_back('{4'(k), wword(k, f, '0, SHIPS_ALL)});
      wq.push_back('{4'd0, 32'd0});
      rq.push_back('{7'd0, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clock);
    req = 1'b1;
    for (int n = 0; n < 600 && done_cnt == d0; n++) @(posedge clock);
    @(posedge clock);
    #1;
    req = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_retrigger busy=%0b required 1", busy); end
    for (int n = 0; n < 600 && done_cnt < d0 + 2; n++) @(posedge clock);
    total++; if (done_cnt != d0 + 2) begin
      bad++; $display("FAIL b2b_dones got=%0d required 2", done_cnt - d0);
    end
    total++; if (wq.size() != 0 || rq.size() != 0) begin
      bad++; $display("FAIL b2b_leftover wq=%0d rq=%0d required 0 0", wq.size(), rq.size());
      wq.delete(); rq.delete();
    end
  endtask

  initial begin
    fork
      engine_stub();
    join_none
    test_reset();
    test_engine_ok();
    test_fallback();
    test_timeout();
    test_no_move();
    test_stall();
    test_reset_midrun();
    test_back_to_back();
    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog run did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ai_sequencer.md
Name: ai_sequencer

Overview:
- Master-side controller for the density-based shot engine (ai) and its 4-bit-address register interface.
- Game FSM requests a move with one handshake. The sequencer snapshots board state and writes the nine config words. It issues start, waits out the engine's busy period, reads the chosen cell and validates it.
- Falls back to a linear scan if the engine's result is illegal or the engine times out.
- Sits between game-control logic and the ai instance; the engine is used only through this block.

Parameters:
- TIMEOUT_CYCLES, 2048: maximum cycles from start write to engine idle before abort (nominal engine run is about 420 cycles).
- CELLS, 100: board cell count; indices 0..CELLS-1.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req  in  1  move request; sampled only in IDLE
- fired_in  in  100  cells already shot
- hits_in  in  100  cells shot and hit (unsunk)
- ships_in  in  5  alive-ship mask, bit0=len2, bit1/2=len3, bit3=len4, bit4=len5
- busy  out  1  high from req accept until done
- done  out  1  one-cycle pulse; result outputs valid in the same cycle and held until next accept
- shot_index  out  7  chosen cell 0..99
- fallback  out  1  shot_index came from linear scan, not the engine
- no_move  out  1  no legal cell exists; shot_index=127
- timeout_err  out  1  engine exceeded TIMEOUT_CYCLES; sticky until next accept
- ai_addr  out  4  engine register address
- ai_write_en  out  1  engine write strobe
- ai_read_en  out  1  engine read strobe
- ai_wdata  out  32  engine write data
- ai_wait_request  in  1  engine busy
- ai_rdata  in  32  engine read data

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE. busy, done, fallback, no_move, timeout_err, ai_write_en, ai_read_en = 0. ai_addr=0, ai_wdata=0, shot_index=0, counters=0. Reset mid-operation aborts immediately; all strobes drop on the same edge.
- All outputs are registered.
- IDLE: on req=1, latch fired_in/hits_in/ships_in into snapshot registers, set busy=1, and clear fallback/no_move/timeout_err.
  - If ships_in==0 or &fired_in: go to DONE with no_move=1 and shot_index=127; the engine is not touched.
  - Otherwise go to LOAD with word=1.
- LOAD: drive ai_write_en=1, ai_addr=word, ai_wdata=W(word), where W is:
  - 1..3: fired[32k-1:32k-32]; 4: {28'd0,fired[99:96]}
  - 5..8: same layout for hits
  - 9: {27'd0,ships}
  - A word is accepted at an edge where ai_wait_request=0. Then word++. After word 9 is accepted, go to START.
  - With ai_wait_request=1 the word is held; there is no timeout in LOAD.
- START: ai_write_en=1, ai_addr=0, ai_wdata=0. On accept (ai_wait_request=0), go to WAIT_BUSY, tmo=0, write_en=0.
- WAIT_BUSY: wait for ai_wait_request=1, then go to WAIT_DONE.
- WAIT_DONE: wait for ai_wait_request=0, then go to READ.
- Timeout: tmo increments every cycle in WAIT_BUSY and WAIT_DONE, saturating. If tmo==TIMEOUT_CYCLES-1 and the exit condition is not met: timeout_err=1, go to SCAN.
- READ: ai_read_en=1, ai_addr=0 for exactly one cycle, then CAPTURE.
- CAPTURE: sample ai_rdata[6:0] into idx (engine data_out is registered, so valid one cycle after the read strobe), then CHECK.
- CHECK:
  - If idx>99 or fired[idx]==1: go to SCAN with pos=0.
  - Else shot_index=idx, go to DONE.
- SCAN: one cell per cycle, pos 0..99.
  - At the first pos with fired[pos]==0: shot_index=pos, fallback=1, go to DONE.
  - Unreachable if no_move was already excluded in IDLE. If pos reaches 99 without a hit, set no_move=1 and shot_index=127.
  - Worst-case latency 100 cycles.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A req held high re-triggers on the next cycle; requests are level-sampled.
- Only one of ai_write_en or ai_read_en is ever high; both are 0 outside LOAD/START/READ.
- Snapshot is immutable during a run; changes on *_in after accept are ignored.

Decomposition:
- Package ai_pkg:
  - ai_addr register enum: START=0, FIRED0..3=1..4, HITS0..3=5..8, SHIPS=9.
  - CELLS and NO_MOVE_IDX=7'd127.
  - Sequencer state enum: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, READ, CAPTURE, CHECK, SCAN, DONE.
  - Ship-mask bit constants.
- Sub-module ai_word_mux (combinational): word index plus snapshot gives the 32-bit W(word).
- Top-level integration instantiates ai_sequencer and ai with shared clock and reset_n.

Test Plan:
- Empty board (fired=hits=0, ships=5'h1F), real ai attached: req → 9 writes at addr 1..9 with W(9)=32'h1F, start write at addr 0, read → done with shot_index=44 (engine's lowest-index density maximum), fallback=0.
- Stub engine returns 7'd0 with fired[0]=1 and fired[1]=1 → fallback=1, shot_index=2, done two scan cycles after CHECK.
- Stub holds ai_wait_request=1 forever after start, TIMEOUT_CYCLES=16 → timeout_err=1 after 16 wait cycles, then SCAN; with fired=0, shot_index=0.
- ships_in=0 → done the cycle after accept, no_move=1, shot_index=127, zero engine strobes.
- Stub asserts ai_wait_request=1 during LOAD word 5 for 3 cycles → word 5 held with ai_addr=5 and identical ai_wdata, no skipped or duplicated words, and the sequence completes.
- Assert reset_n=0 during WAIT_DONE → next cycle busy=0, strobes=0, state IDLE; a new req then completes normally.
